// File: rtl/regfile_mp.sv
// Multi-read-port register file for the ID stage: hardwired zero register,
// write-to-read bypass, link override and a clear sequence run after every reset.
module regfile_mp #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int NUM_RD   = 2,
   parameter int LINK_REG = 31,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 ready,
   input  logic                 wr_en,
   input  logic                 link,
   input  logic [AW-1:0]        wr_addr,
   input  logic [DW-1:0]        wr_data,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   input  logic [AW-1:0]        dbg_addr,
   output logic [DW-1:0]        dbg_data
);

   localparam int            DEPTH  = 1 << AW;
   localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
   localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);
   localparam logic          HAS_Z  = (ZERO_REG != 0);

   typedef enum logic {INIT, RUN} state_t;

   state_t              state;
   logic [AW-1:0]       clrPtr;
   logic [DW-1:0]       mem [DEPTH];
   logic [AW-1:0]       dest;
   logic                destOk;
   logic [NUM_RD*DW-1:0] rdNext;

   assign dest     = link ? LINK_A : wr_addr;
   assign destOk   = !(HAS_Z && (dest == '0));
   assign dbg_data = mem[dbg_addr];

   // A read that hits the entry being written this cycle sees the new data.
   always_comb begin
      rdNext = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (HAS_Z && (rd_addr[i*AW +: AW] == '0))
            rdNext[i*DW +: DW] = '0;
         else if (wr_en && destOk && (dest == rd_addr[i*AW +: AW]))
            rdNext[i*DW +: DW] = wr_data;
         else
            rdNext[i*DW +: DW] = mem[rd_addr[i*AW +: AW]];
      end
   end

   // INIT walks every entry writing zero; RUN performs normal writes and reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= INIT;
         clrPtr  <= '0;
         ready   <= 1'b0;
         rd_data <= '0;
      end else begin
         case (state)
            INIT: begin
               mem[clrPtr] <= '0;
               clrPtr      <= clrPtr + 1'b1;
               rd_data     <= '0;
               if (clrPtr == LAST_A) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               if (wr_en && destOk)
                  mem[dest] <= wr_data;
               rd_data <= rdNext;
               ready   <= 1'b1;
            end
            default: begin
               state <= INIT;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp against an array-based model of the
// architectural register contents.
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          ready;
   logic          wr_en;
   logic          link;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;

   int vectors = 0;
   int miscompares = 0;
   logic [DW-1:0] model [DEPTH];

   regfile_mp #(.DW(DW), .AW(AW), .NUM_RD(NR), .LINK_REG(31), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .ready(ready), .wr_en(wr_en), .link(link),
      .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
      .rd_data(rd_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Expected architectural value of a register as software sees it.
   function automatic logic [DW-1:0] regValue(input int a);
      return (a == 0) ? '0 : model[a];
   endfunction

   // One RUN-mode cycle: the model commits the write first, then every read
   // issued that cycle must observe the post-write register contents.
   task automatic applyStimulus(input logic wen, input logic lnk, input int waddr,
                                input logic [DW-1:0] wdata, input int ra0, input int ra1);
      int d;
      wr_en   = wen;
      link    = lnk;
      wr_addr = AW'(waddr);
      wr_data = wdata;
      rd_addr = {AW'(ra1), AW'(ra0)};
      @(posedge clk);
      d = lnk ? 31 : waddr;
      if (wen && d != 0) model[d] = wdata;
      #1;
      wr_en = 1'b0;
      link  = 1'b0;
      checkOutput("rd0", rd_data[0 +: DW], regValue(ra0));
      checkOutput("rd1", rd_data[DW +: DW], regValue(ra1));
      checkOutput("ready_run", {31'b0, ready}, 32'd1);
   endtask

   task automatic checkDbg(input int a);
      dbg_addr = AW'(a);
      #1;
      checkOutput($sformatf("dbg[%0d]", a), dbg_data, regValue(a));
   endtask

   initial begin
      logic [DW-1:0] r9Before;
      logic [DW-1:0] r3Before;
      int wa, r0, r1;
      rst = 1'b1; wr_en = 1'b0; link = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; dbg_addr = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;

      @(posedge clk); #1;
      checkOutput("reset_ready", {31'b0, ready}, 32'd0);
      checkOutput("reset_rd", rd_data[0 +: DW] | rd_data[DW +: DW], 32'd0);
      rst = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk); #1;
         checkOutput("init1_ready", {31'b0, ready}, 32'd0);
      end

      // Second reset arrives mid-clear; the full clear must restart.
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("rerst_ready", {31'b0, ready}, 32'd0);
      checkOutput("rerst_rd", rd_data[0 +: DW], 32'd0);
      rst = 1'b0;
      rd_addr = {AW'(4), AW'(2)};
      for (int n = 1; n <= DEPTH; n++) begin
         if (n == 20) begin
            wr_en = 1'b1; wr_addr = AW'(9); wr_data = 32'hA5A5_0009;
         end
         @(posedge clk); #1;
         wr_en = 1'b0;
         checkOutput($sformatf("init2_ready_c%0d", n), {31'b0, ready}, (n == DEPTH) ? 32'd1 : 32'd0);
         if (n < DEPTH) checkOutput("init2_rd", rd_data[DW +: DW], 32'd0);
      end
      for (int i = 0; i < DEPTH; i++) checkDbg(i);

      // Basic write then read.
      applyStimulus(1'b1, 1'b0, 5, 32'hDEADBEEF, 1, 2);
      applyStimulus(1'b0, 1'b0, 0, 32'h0, 5, 9);
      checkOutput("basic_r5", rd_data[0 +: DW], 32'hDEADBEEF);
      checkOutput("init_write_r9", rd_data[DW +: DW], 32'd0);

      // Same-cycle bypass on port 1.
      applyStimulus(1'b1, 1'b0, 7, 32'h0000_1234, 0, 7);
      checkOutput("bypass_r7", rd_data[DW +: DW], 32'h0000_1234);

      // Zero register ignores writes.
      applyStimulus(1'b1, 1'b0, 0, 32'hFFFFFFFF, 0, 0);
      applyStimulus(1'b0, 1'b0, 0, 32'h0, 0, 0);
      checkOutput("zero_p0", rd_data[0 +: DW], 32'd0);
      checkOutput("zero_p1", rd_data[DW +: DW], 32'd0);
      checkDbg(0);

      // Link override targets r31 and leaves wr_addr untouched.
      r3Before = model[3];
      applyStimulus(1'b1, 1'b1, 3, 32'h0040_0008, 31, 3);
      checkOutput("link_r31", rd_data[0 +: DW], 32'h0040_0008);
      checkOutput("link_r3", rd_data[DW +: DW], r3Before);
      checkDbg(31);
      checkDbg(3);

      // link without wr_en is a no-op.
      applyStimulus(1'b0, 1'b1, 3, 32'h1111_2222, 31, 3);
      checkOutput("link_nowr", rd_data[0 +: DW], 32'h0040_0008);

      r9Before = model[9];
      checkOutput("r9_model", r9Before, 32'd0);

      for (int k = 0; k < 400; k++) begin
         wa = $urandom_range(0, DEPTH - 1);
         r0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
         r1 = ($urandom_range(0, 3) == 0) ? wa : (($urandom_range(0, 4) == 0) ? r0 : $urandom_range(0, DEPTH - 1));
         applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                       wa, $urandom, r0, r1);
         checkDbg($urandom_range(0, DEPTH - 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
